// File: rtl/t_ff_counter_pkg.sv
// ---------------------------------------------------------------------------
// Package: t_ff_pkg
// Purpose: shared definitions for the T flip-flop counter family.
//   MODE_COUNT  - bank behaves as a modulo up/down counter
//   MODE_TOGGLE - every cell toggles independently on its own T request
//   clog2       - elaboration-time ceiling log2 helper for sizing counters
// ---------------------------------------------------------------------------
package t_ff_pkg;

    localparam logic MODE_COUNT  = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    // Ceiling log2, returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/t_ff_counter_cell.sv
// ---------------------------------------------------------------------------
// Module: t_ff_cell
// Purpose: single-bit T flip-flop with synchronous active-high reset and a
//          synchronous parallel load. Priority: reset > load > t.
// Ports:
//   clk     in  1  rising-edge clock
//   reset   in  1  synchronous, active-high; forces q to RESET_VALUE
//   load    in  1  loads load_d into q
//   load_d  in  1  value taken when load is high
//   t       in  1  toggle request
//   q       out 1  cell state
// ---------------------------------------------------------------------------
module t_ff_cell #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_d,
    input  logic t,
    output logic q
);

    // State bit: reset wins, then a parallel load, otherwise toggle on request.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= load_d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/t_ff_counter.sv
// ---------------------------------------------------------------------------
// Module: t_ff_counter
// Purpose: WIDTH-bit bank of T flip-flop cells usable either as independent
//          toggle channels or as a modulo-(MAX_COUNT+1) up/down counter. The
//          counter logic only ever changes Q through the cells' toggle inputs;
//          the only direct write is the synchronous load.
// Configuration:
//   T_FF_COUNTER_SATURATE_EN - when defined, counting saturates at 0 and
//   MAX_COUNT instead of wrapping, and wrap pulses for every blocked step.
// Ports:
//   clk         in  1      rising-edge clock
//   reset       in  1      synchronous, active-high reset
//   en          in  1      advance enable (load is honoured even when low)
//   mode        in  1      MODE_COUNT (0) or MODE_TOGGLE (1)
//   up          in  1      count direction in MODE_COUNT (1 = up)
//   T           in  WIDTH  per-bit toggle request in MODE_TOGGLE
//   load        in  1      synchronous load of load_value
//   load_value  in  WIDTH  load data, clamped to MAX_COUNT in MODE_COUNT
//   Q           out WIDTH  cell outputs / count value
//   tc          out 1      combinational terminal count
//   wrap        out 1      registered pulse the cycle after a wrap/blocked step
// ---------------------------------------------------------------------------
module t_ff_counter
    import t_ff_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MAX_COUNT   = 2**WIDTH - 1,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             up,
    input  logic [WIDTH-1:0] T,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

    logic [WIDTH-1:0] q_cells;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] toggle_vec;
    logic [WIDTH-1:0] load_d;
    logic             wrap_next;

    assign Q = q_cells;

    // Next-state for an enabled step. A count value left above MAX_COUNT by
    // toggle mode is pulled back into range (0 going up, MAX going down)
    // without flagging a wrap, since no real terminal count was passed.
    always_comb begin
        q_next    = q_cells;
        wrap_next = 1'b0;
        if (en) begin
            if (mode == MODE_TOGGLE) begin
                q_next = q_cells ^ T;
            end else if (q_cells > MAX_Q) begin
                q_next = up ? '0 : MAX_Q;
            end else if (up) begin
                if (q_cells == MAX_Q) begin
`ifdef T_FF_COUNTER_SATURATE_EN
                    q_next    = MAX_Q;
`else
                    q_next    = '0;
`endif
                    wrap_next = 1'b1;
                end else begin
                    q_next = q_cells + ONE_Q;
                end
            end else begin
                if (q_cells == '0) begin
`ifdef T_FF_COUNTER_SATURATE_EN
                    q_next    = '0;
`else
                    q_next    = MAX_Q;
`endif
                    wrap_next = 1'b1;
                end else begin
                    q_next = q_cells - ONE_Q;
                end
            end
        end
    end

    // Load data: clamp only when the bank is being used as a counter.
    always_comb begin
        load_d = load_value;
        if (mode == MODE_COUNT && load_value > MAX_Q) begin
            load_d = MAX_Q;
        end
    end

    // Each cell flips exactly the bits that differ between now and next.
    assign toggle_vec = q_cells ^ q_next;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            t_ff_cell #(
                .RESET_VALUE(RESET_Q[i])
            ) u_cell (
                .clk   (clk),
                .reset (reset),
                .load  (load),
                .load_d(load_d[i]),
                .t     (toggle_vec[i]),
                .q     (q_cells[i])
            );
        end
    endgenerate

    // Terminal count looks at the live inputs so it can gate a cascade stage
    // in the same cycle.
    assign tc = (mode == MODE_COUNT) && en && (q_cells == (up ? MAX_Q : '0));

    // Wrap pulse register: cleared by reset and load, otherwise reports
    // whether the step just taken wrapped (or was blocked).
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_t_ff_counter.sv
// ---------------------------------------------------------------------------
// Testbench: tb_t_ff_counter
// Purpose: directed scenarios followed by randomized traffic for t_ff_counter
//          (WIDTH=4, MAX_COUNT=9, RESET_VALUE=0), compared each cycle with an
//          arithmetic reference model. Honours T_FF_COUNTER_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_t_ff_counter;

    localparam int WIDTH       = 4;
    localparam int MAX_COUNT   = 9;
    localparam int RESET_VALUE = 0;
    localparam int MODULUS     = MAX_COUNT + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             mode;
    logic             up;
    logic [WIDTH-1:0] t_req;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] q_out;
    logic             tc;
    logic             wrap;

    int model_q;
    int model_wrap;
    int tests_run    = 0;
    int tests_failed = 0;

    t_ff_counter #(
        .WIDTH      (WIDTH),
        .MAX_COUNT  (MAX_COUNT),
        .RESET_VALUE(RESET_VALUE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .up        (up),
        .T         (t_req),
        .load      (load),
        .load_value(load_value),
        .Q         (q_out),
        .tc        (tc),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // Reference model of one rising edge, written from the arithmetic rules:
    // modulo counting, clamped loads, XOR toggles.
    task automatic modelStep();
        int lv;
        lv = int'(load_value);
        if (reset) begin
            model_q    = RESET_VALUE;
            model_wrap = 0;
        end else if (load) begin
            model_q    = (mode == 1'b0 && lv > MAX_COUNT) ? MAX_COUNT : lv;
            model_wrap = 0;
        end else if (!en) begin
            model_wrap = 0;
        end else if (mode == 1'b1) begin
            model_q    = model_q ^ int'(t_req);
            model_wrap = 0;
        end else if (model_q > MAX_COUNT) begin
            model_q    = up ? 0 : MAX_COUNT;
            model_wrap = 0;
        end else begin
`ifdef T_FF_COUNTER_SATURATE_EN
            if (up && model_q == MAX_COUNT) begin
                model_wrap = 1;
            end else if (!up && model_q == 0) begin
                model_wrap = 1;
            end else begin
                model_q    = up ? model_q + 1 : model_q - 1;
                model_wrap = 0;
            end
`else
            model_wrap = (up && model_q == MAX_COUNT) || (!up && model_q == 0) ? 1 : 0;
            model_q    = up ? (model_q + 1) % MODULUS : (model_q + MODULUS - 1) % MODULUS;
`endif
        end
    endtask

    // Drive one cycle's inputs, clock them in and advance the model.
    task automatic applyStimulus(input logic r, input logic e, input logic m,
                                 input logic u, input logic [WIDTH-1:0] t,
                                 input logic l, input logic [WIDTH-1:0] lv);
        reset      = r;
        en         = e;
        mode       = m;
        up         = u;
        t_req      = t;
        load       = l;
        load_value = lv;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    // Compare Q, wrap and tc against the model; tc uses the inputs still applied.
    task automatic checkOutput(input string tag);
        logic [WIDTH-1:0] exp_q;
        logic             exp_wrap;
        logic             exp_tc;
        exp_q    = WIDTH'(model_q);
        exp_wrap = (model_wrap != 0);
        exp_tc   = (mode == 1'b0) && en && (model_q == (up ? MAX_COUNT : 0));

        tests_run++;
        assert (q_out === exp_q) else begin
            tests_failed++;
            $error("[TB] FAIL %s Q: observed %h expected %h", tag, q_out, exp_q);
        end
        tests_run++;
        assert (wrap === exp_wrap) else begin
            tests_failed++;
            $error("[TB] FAIL %s wrap: observed %b expected %b", tag, wrap, exp_wrap);
        end
        tests_run++;
        assert (tc === exp_tc) else begin
            tests_failed++;
            $error("[TB] FAIL %s tc: observed %b expected %b", tag, tc, exp_tc);
        end
    endtask

    initial begin
        model_q    = RESET_VALUE;
        model_wrap = 0;
        reset      = 1'b1;
        en         = 1'b1;
        mode       = 1'b0;
        up         = 1'b1;
        t_req      = '0;
        load       = 1'b0;
        load_value = '0;
        @(negedge clk);

        // Reset held two cycles with en high: Q must stay at reset value.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
            checkOutput("reset");
        end

        // Count up twelve steps: 1..9, 0 (wrap), 1, 2.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
            checkOutput("count_up");
        end

        // Step down to 1, then three more down steps across zero.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        checkOutput("down_to_one");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
            checkOutput("count_down");
        end

        // Toggle mode from zero with T=1010, then hold with en low.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0);
        checkOutput("toggle_clear");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b0, 4'h0);
            checkOutput("toggle_step");
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b1010, 1'b0, 4'h0);
        checkOutput("toggle_set");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 4'h0);
            checkOutput("toggle_hold");
        end

        // Load F: clamped to 9 when counting, raw when toggling, then recover.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 4'hF);
        checkOutput("load_clamp");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 4'hF);
        checkOutput("load_raw");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
        checkOutput("out_of_range_up");

        // Reset together with load while counting at 5.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 4'h4);
        checkOutput("load_four");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
        checkOutput("at_five");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 4'h7);
        checkOutput("reset_over_load");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
        checkOutput("after_reset");

        // Randomized traffic: occasional reset/load, mixed modes and directions.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0),
                          1'($urandom),
                          4'($urandom),
                          ($urandom_range(0, 9) == 0),
                          4'($urandom));
            checkOutput("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
